// File: rtl/video_sync_gen.sv
// ============================================================================
// Module      : video_sync_gen
// Description : Transmit-side raster timing generator: hsync/vsync with fixed
//               polarity, blanking, data-enable, coordinates, frame strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_sync_gen #(
    parameter int H_ACTIVE = 160,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 40,
    parameter int V_ACTIVE = 144,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int H_POL    = 1,
    parameter int V_POL    = 1,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pix,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
            V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
            CW <= 0 || H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW)) begin : g_bad_params
            $error("video_sync_gen: zero timing parameter or total exceeds 2**CW");
        end
    endgenerate

    localparam logic [CW-1:0] c_H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] c_V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] c_H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] c_V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          c_H_ON       = (H_POL != 0);
    localparam logic          c_V_ON       = (V_POL != 0);

    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_hblank;
    logic          r_vblank;
    logic          r_de;
    logic          r_frame_start;

    logic          w_h_wrap;
    logic [CW-1:0] w_hc_nxt;
    logic [CW-1:0] w_vc_nxt;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_hb_nxt;
    logic          w_vb_nxt;

    // Flags are decoded from the counter values about to be loaded, so the
    // registered flags always describe the registered coordinate.
    always_comb begin
        w_h_wrap = (r_hc == c_H_LAST);
        w_hc_nxt = w_h_wrap ? '0 : r_hc + CW'(1);
        w_vc_nxt = r_vc;
        if (w_h_wrap) begin
            w_vc_nxt = (r_vc == c_V_LAST) ? '0 : r_vc + CW'(1);
        end
        w_hs_act = (w_hc_nxt >= c_H_SYNC_BEG) && (w_hc_nxt < c_H_SYNC_END);
        w_vs_act = (w_vc_nxt >= c_V_SYNC_BEG) && (w_vc_nxt < c_V_SYNC_END);
        w_hb_nxt = (w_hc_nxt >= c_H_ACT_END);
        w_vb_nxt = (w_vc_nxt >= c_V_ACT_END);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_hsync       <= ~c_H_ON;
            r_vsync       <= ~c_V_ON;
            r_hblank      <= 1'b0;
            r_vblank      <= 1'b0;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (ce_pix) begin
            r_hc          <= w_hc_nxt;
            r_vc          <= w_vc_nxt;
            r_hsync       <= w_hs_act ? c_H_ON : ~c_H_ON;
            r_vsync       <= w_vs_act ? c_V_ON : ~c_V_ON;
            r_hblank      <= w_hb_nxt;
            r_vblank      <= w_vb_nxt;
            r_de          <= ~w_hb_nxt & ~w_vb_nxt;
            r_frame_start <= (w_hc_nxt == '0) && (w_vc_nxt == '0);
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign de          = r_de;
    assign x           = r_hc;
    assign y           = r_vc;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_video_sync_gen.sv
// ============================================================================
// Module      : tb_video_sync_gen
// Description : Directed self-checking bench for video_sync_gen (small
//               configurations of both polarities plus default timing).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic ce    = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [11:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic hs_a, vs_a, hb_a, vb_a, de_a, fs_a;
    logic hs_b, vs_b, hb_b, vb_b, de_b, fs_b;
    logic hs_c, vs_c, hb_c, vb_c, de_c, fs_c;
    logic [29:0] obs_a, obs_b;

    assign obs_a = {x_a, y_a, hs_a, vs_a, hb_a, vb_a, de_a, fs_a};
    assign obs_b = {x_b, y_b, hs_b, vs_b, hb_b, vb_b, de_b, fs_b};

    video_sync_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(1), .V_POL(1), .CW(12)) u_dut_a (
        .clk(clk), .reset(reset), .ce_pix(ce),
        .hsync(hs_a), .vsync(vs_a), .hblank(hb_a), .vblank(vb_a), .de(de_a),
        .x(x_a), .y(y_a), .frame_start(fs_a));

    video_sync_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                     .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .H_POL(0), .V_POL(0), .CW(12)) u_dut_b (
        .clk(clk), .reset(reset), .ce_pix(ce),
        .hsync(hs_b), .vsync(vs_b), .hblank(hb_b), .vblank(vb_b), .de(de_b),
        .x(x_b), .y(y_b), .frame_start(fs_b));

    video_sync_gen u_dut_c (
        .clk(clk), .reset(reset), .ce_pix(ce),
        .hsync(hs_c), .vsync(vs_c), .hblank(hb_c), .vblank(vb_c), .de(de_c),
        .x(x_c), .y(y_c), .frame_start(fs_c));

    // Expected outputs of the 8x6 raster at linear position p (steady state).
    function automatic logic [29:0] exp_small(input int p, input logic hp, input logic vp);
        int   h;
        int   v;
        logic hs, vs, hb, vb;
        h  = p % 8;
        v  = p / 8;
        hs = (h == 5 || h == 6) ? hp : ~hp;
        vs = (v == 4) ? vp : ~vp;
        hb = (h >= 4);
        vb = (v >= 3);
        return {12'(h), 12'(v), hs, vs, hb, vb, ~hb & ~vb, (p == 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ce    = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_a !== {24'd0, 6'b000000}) begin
            errors++;
            $display("FAIL reset_a: got %h want %h", obs_a, {24'd0, 6'b000000});
        end
        checks++;
        if (obs_b !== {24'd0, 6'b110000}) begin
            errors++;
            $display("FAIL reset_b: got %h want %h", obs_b, {24'd0, 6'b110000});
        end
    endtask

    task automatic test_basic();
        do_reset();
        ce = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            tick();
            checks++;
            if (obs_a !== exp_small(k % 48, 1'b1, 1'b1)) begin
                errors++;
                $display("FAIL basic k=%0d: got %h want %h", k, obs_a, exp_small(k % 48, 1'b1, 1'b1));
            end
        end
    endtask

    task automatic test_polarity();
        do_reset();
        checks++;
        if ({hs_b, vs_b} !== 2'b11) begin
            errors++;
            $display("FAIL pol_reset: got %b want 11", {hs_b, vs_b});
        end
        ce = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            tick();
            checks++;
            if (obs_b !== exp_small(k % 48, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL polarity k=%0d: got %h want %h", k, obs_b, exp_small(k % 48, 1'b0, 1'b0));
            end
        end
    endtask

    task automatic test_ce_toggle();
        int   pos;
        int   fs_hi;
        logic cur;
        do_reset();
        pos   = 0;
        fs_hi = 0;
        for (int k = 1; k <= 192; k++) begin
            ce  = (k % 2 == 1);
            cur = ce;
            tick();
            if (cur) pos = (pos + 1) % 48;
            if (fs_a) fs_hi++;
            checks++;
            if (obs_a !== exp_small(pos, 1'b1, 1'b1)) begin
                errors++;
                $display("FAIL ce_toggle k=%0d: got %h want %h", k, obs_a, exp_small(pos, 1'b1, 1'b1));
            end
        end
        checks++;
        if (fs_hi !== 4) begin
            errors++;
            $display("FAIL ce_fs_count: got %0d want 4", fs_hi);
        end
    endtask

    task automatic test_reset_mid_sync();
        do_reset();
        ce = 1'b1;
        repeat (37) tick();
        checks++;
        if ({x_a, y_a, hs_a, vs_a} !== {12'd5, 12'd4, 2'b11}) begin
            errors++;
            $display("FAIL pre_reset: got %h want %h", {x_a, y_a, hs_a, vs_a}, {12'd5, 12'd4, 2'b11});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({x_a, y_a, hs_a, vs_a, de_a, fs_a} !== {24'd0, 4'b0000}) begin
            errors++;
            $display("FAIL async_reset_a: got %h want %h", {x_a, y_a, hs_a, vs_a, de_a, fs_a}, {24'd0, 4'b0000});
        end
        checks++;
        if ({hs_b, vs_b} !== 2'b11) begin
            errors++;
            $display("FAIL async_reset_b: got %b want 11", {hs_b, vs_b});
        end
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            tick();
            checks++;
            if (obs_a !== exp_small(k % 48, 1'b1, 1'b1)) begin
                errors++;
                $display("FAIL restart k=%0d: got %h want %h", k, obs_a, exp_small(k % 48, 1'b1, 1'b1));
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        ce = 1'b1;
        repeat (47) tick();
        checks++;
        if ({x_a, y_a} !== {12'd7, 12'd5}) begin
            errors++;
            $display("FAIL wrap_pre: got x=%0d y=%0d want x=7 y=5", x_a, y_a);
        end
        tick();
        checks++;
        if ({x_a, y_a} !== 24'd0) begin
            errors++;
            $display("FAIL wrap_xy: got x=%0d y=%0d want 0 0", x_a, y_a);
        end
        checks++;
        if (fs_a !== 1'b1) begin
            errors++;
            $display("FAIL wrap_fs: got %b want 1", fs_a);
        end
        checks++;
        if ({vs_a, hb_a, vb_a, de_a} !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_flags: got %b want 0001", {vs_a, hb_a, vb_a, de_a});
        end
    endtask

    task automatic test_default_frame();
        int   hs_rises, bad_w, run, vs_cyc, vs_rises, vs_misal, de_cnt, fs_cnt;
        logic p_hs, p_vs;
        hs_rises = 0; bad_w = 0; run = 0; vs_cyc = 0; vs_rises = 0;
        vs_misal = 0; de_cnt = 0; fs_cnt = 0;
        do_reset();
        p_hs = hs_c;
        p_vs = vs_c;
        ce   = 1'b1;
        for (int k = 1; k <= 240 * 172; k++) begin
            tick();
            if (hs_c && !p_hs) hs_rises++;
            if (hs_c) run++;
            if (!hs_c && p_hs) begin
                if (run != 32) bad_w++;
                run = 0;
            end
            if (vs_c) vs_cyc++;
            if (vs_c && !p_vs) vs_rises++;
            if (vs_c != p_vs && x_c != 12'd0) vs_misal++;
            if (de_c) de_cnt++;
            if (fs_c) fs_cnt++;
            p_hs = hs_c;
            p_vs = vs_c;
        end
        checks++;
        if (hs_rises !== 172) begin
            errors++;
            $display("FAIL dflt_hs_pulses: got %0d want 172", hs_rises);
        end
        checks++;
        if (bad_w !== 0) begin
            errors++;
            $display("FAIL dflt_hs_width: got %0d bad pulses want 0", bad_w);
        end
        checks++;
        if ({vs_rises, vs_cyc} !== {32'd1, 32'd1200}) begin
            errors++;
            $display("FAIL dflt_vsync: got %0d pulses %0d cycles want 1 pulse 1200 cycles", vs_rises, vs_cyc);
        end
        checks++;
        if (vs_misal !== 0) begin
            errors++;
            $display("FAIL dflt_vs_align: got %0d mid-line changes want 0", vs_misal);
        end
        checks++;
        if (de_cnt !== 23040) begin
            errors++;
            $display("FAIL dflt_de: got %0d want 23040", de_cnt);
        end
        checks++;
        if ({fs_cnt, fs_c} !== {32'd1, 1'b1}) begin
            errors++;
            $display("FAIL dflt_fs: got count %0d last %b want 1 and 1", fs_cnt, fs_c);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_polarity();
        test_ce_toggle();
        test_reset_mid_sync();
        test_wrap();
        test_default_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
